// File: rtl/rst_seq_ctrl.sv
// Sequenced reset controller: holds every domain reset for a minimum time after
// the last request, then releases the domains one by one in ascending order.
module rst_seq_ctrl #(
  parameter int NUMBER_OF_RSTS    = 4,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int RELEASE_STEP      = 8,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rst_req_async,
  input  logic                      sw_rst_req,
  output logic [NUMBER_OF_RSTS-1:0] rst_out,
  output logic [NUMBER_OF_RSTS-1:0] rst_n_out,
  output logic                      rst_done
);
  localparam int MAXC = (MIN_ASSERT_CYCLES > RELEASE_STEP) ? MIN_ASSERT_CYCLES : RELEASE_STEP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUMBER_OF_RSTS) + 1;
  localparam logic [CW-1:0] HOLD_END = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] STEP_END = CW'(RELEASE_STEP - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUMBER_OF_RSTS - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req;

  assign req       = sync[SYNC_STAGES-1] | sw_rst_req;
  assign rst_n_out = ~rst_out;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], rst_req_async};
  end

  // Releases shift a zero in from the bottom, so bits can only ever clear in
  // ascending order and can only set all together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      cnt      <= '0;
      idx      <= '0;
      rst_out  <= '1;
      rst_done <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (req) begin
            cnt <= '0;
          end else if (cnt == HOLD_END) begin
            rst_out <= rst_out << 1;
            idx     <= IW'(1);
            cnt     <= '0;
            if (NUMBER_OF_RSTS == 1) begin
              state    <= DONE;
              rst_done <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (req) begin
            rst_out <= '1;
            cnt     <= '0;
            idx     <= '0;
            state   <= HOLD;
          end else if (cnt == STEP_END) begin
            rst_out <= rst_out << 1;
            idx     <= idx + 1'b1;
            cnt     <= '0;
            if (idx == LAST_IDX) begin
              state    <= DONE;
              rst_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (req) begin
            rst_out  <= '1;
            rst_done <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            state    <= HOLD;
          end
        end
        default: begin
          state   <= HOLD;
          rst_out <= '1;
          cnt     <= '0;
          idx     <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a default instance and a 1/1/1 corner instance share
// stimulus; expectations come from "edges since last request" arithmetic.
module tb_rst_seq_ctrl;
  localparam int N = 4, MIN = 16, STEP = 8, SS = 2;

  logic clk = 1'b0, rst = 1'b1, rst_req_async = 1'b0, sw_rst_req = 1'b0;
  logic [N-1:0] rst_out, rst_n_out;
  logic         rst_done;
  logic [0:0]   c_out, c_n_out;
  logic         c_done;

  int total = 0, bad = 0;
  int n_quiet = 0;          // req-free, rst-free edges since last restart
  logic [SS-1:0] hist = '0; // async samples still in flight to the request

  always #5 clk = ~clk;

  rst_seq_ctrl #(.NUMBER_OF_RSTS(N), .MIN_ASSERT_CYCLES(MIN), .RELEASE_STEP(STEP),
                 .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .rst_req_async(rst_req_async), .sw_rst_req(sw_rst_req),
    .rst_out(rst_out), .rst_n_out(rst_n_out), .rst_done(rst_done));

  rst_seq_ctrl #(.NUMBER_OF_RSTS(1), .MIN_ASSERT_CYCLES(1), .RELEASE_STEP(1),
                 .SYNC_STAGES(SS)) dut_c (
    .clk(clk), .rst(rst), .rst_req_async(rst_req_async), .sw_rst_req(sw_rst_req),
    .rst_out(c_out), .rst_n_out(c_n_out), .rst_done(c_done));

  // Bit i is released once MIN + i*STEP quiet edges have passed.
  function automatic logic [3:0] exp_bits(int n, int nr, int mn, int st);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < nr; i++) r[i] = (n < mn + i * st);
    return r;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, expv);
    end
  endtask

  task automatic step(logic r, logic a, logic s);
    logic       req;
    logic [3:0] e, ec;
    rst_req_async = a; sw_rst_req = s; rst = r;
    @(posedge clk);
    if (r) begin
      hist    = '0;
      n_quiet = 0;
    end else begin
      req  = hist[SS-1] | s;
      hist = {hist[SS-2:0], a};
      if (req) n_quiet = 0;
      else if (n_quiet < 10000) n_quiet++;
    end
    @(negedge clk);
    e  = exp_bits(n_quiet, N, MIN, STEP);
    ec = exp_bits(n_quiet, 1, 1, 1);
    chk("rst_out",   rst_out, e);
    chk("rst_n_out", rst_n_out, ~e);
    chk("rst_done",  {3'b0, rst_done}, {3'b0, n_quiet >= MIN + (N - 1) * STEP});
    chk("c_rst_out", {3'b0, c_out}, ec);
    chk("c_rst_n",   {3'b0, c_n_out}, {3'b0, ~ec[0]});
    chk("c_done",    {3'b0, c_done}, {3'b0, n_quiet >= 1});
  endtask

  initial begin
    logic a_hold;
    // power-on: full staggered release
    repeat (3) step(1, 0, 0);
    repeat (45) step(0, 0, 0);
    // software request while DONE, then full re-release
    step(0, 0, 1);
    repeat (45) step(0, 0, 0);
    // async request held 5 cycles, drained through the synchronizer
    repeat (5) step(0, 1, 0);
    repeat (50) step(0, 0, 0);
    // abort during RELEASE at E28
    repeat (2) step(1, 0, 0);
    repeat (27) step(0, 0, 0);
    step(0, 0, 1);
    repeat (45) step(0, 0, 0);
    // rst reasserted at E30 for 2 cycles, with a request it must override
    repeat (2) step(1, 0, 0);
    repeat (29) step(0, 0, 0);
    step(1, 0, 1);
    step(1, 1, 0);
    repeat (45) step(0, 0, 0);
    // back-to-back software pulses
    repeat (3) begin step(0, 0, 1); repeat (5) step(0, 0, 0); end
    repeat (45) step(0, 0, 0);
    // randomized traffic
    a_hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) a_hold = ~a_hold;
      step($urandom_range(0, 199) == 0, a_hold, $urandom_range(0, 34) == 0);
    end
    repeat (45) step(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

- Sequenced reset controller: the consuming end of the clock/reset interface.
- Takes the single testbench- or board-driven clock and reset plus later reset requests.
- Produces `NUMBER_OF_RSTS` per-domain synchronous resets that release in a fixed, staggered order after a guaranteed minimum assertion time.
- Sits between the clock/reset source and the DUT's reset domains; provides a completion flag for sequences and scoreboards.

## Interface

Parameters:
- `NUMBER_OF_RSTS`, 4: number of sequenced reset outputs, ≥1.
- `MIN_ASSERT_CYCLES`, 16: minimum cycles all outputs stay asserted after the last request, ≥1.
- `RELEASE_STEP`, 8: cycles between consecutive output releases, ≥1.
- `SYNC_STAGES`, 2: synchronizer depth for `rst_req_async`, ≥2.

Ports:
- `clk`  in  1  sole clock. All logic is on the rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `rst_req_async`  in  1  asynchronous level reset request.
- `sw_rst_req`  in  1  synchronous single-cycle reset request pulse.
- `rst_out`  out  NUMBER_OF_RSTS  per-domain active-high resets. Bit 0 releases first.
- `rst_n_out`  out  NUMBER_OF_RSTS  combinational `~rst_out`.
- `rst_done`  out  1  high when all outputs are released.

## Operation

- Reset values while `rst`=1:
  - `rst_out` all ones, so `rst_n_out` is all zeros.
  - `rst_done`=0.
  - State HOLD, counter 0, release index 0.
  - Synchronizer flops cleared to 0.
- Request: `req` = synchronized `rst_req_async` (last stage) OR `sw_rst_req`.
- States:
  - HOLD:
    - All outputs asserted.
    - Counter increments each cycle.
    - `req`=1 forces the counter to 0.
    - At counter==MIN_ASSERT_CYCLES-1 with `req`=0:
      - Clear `rst_out[0]`, set index=1, clear the counter.
      - If NUMBER_OF_RSTS==1, go to DONE. Otherwise go to RELEASE.
  - RELEASE:
    - Counter increments each cycle.
    - At counter==RELEASE_STEP-1, clear `rst_out[index]`, increment index and clear the counter.
    - When the last bit clears, go to DONE.
    - `req`=1 aborts the release: all bits reassert on that edge, counter and index go to 0, return to HOLD.
  - DONE:
    - `rst_done`=1, all outputs deasserted.
    - `req`=1: on that edge reassert all outputs, clear `rst_done`, counter to 0, go to HOLD.
- Ordering:
  - Outputs only ever release in ascending index order.
  - Outputs always reassert all together, on the same edge.
  - No output bit ever glitches.
- Counter width: `$clog2(max(MIN_ASSERT_CYCLES, RELEASE_STEP)+1)`. The counter never wraps; every state transition clears it.
- `rst_done` is registered and rises on the same edge that clears the last `rst_out` bit.
- `rst` asserted mid-sequence, in any state, restores the reset values on the next edge. `rst` has priority over `req`.

## Timing

- Let E1 be the first rising edge with `rst`=0, and assume no requests.
  - `rst_out[i]` falls at edge E(MIN_ASSERT_CYCLES + i·RELEASE_STEP).
  - `rst_done` rises at edge E(MIN_ASSERT_CYCLES + (NUMBER_OF_RSTS-1)·RELEASE_STEP).
  - Defaults: bits fall at E16, E24, E32 and E40; `rst_done` rises at E40.
- `sw_rst_req` high at edge k: all outputs assert after edge k, a latency of 1 cycle.
- `rst_req_async` stable high, first sampled at edge k: all outputs assert after edge k+SYNC_STAGES.
- Release after a request: `rst_out[0]` falls MIN_ASSERT_CYCLES edges after the last edge that saw `req`=1.
- Back-to-back `sw_rst_req` pulses: each pulse restarts the HOLD count.

## Test plan

- Power-on, defaults: drop `rst`, then hold all requests low.
  - `rst_out` steps 1111 → 1110 at E16 → 1100 at E24 → 1000 at E32 → 0000 at E40.
  - `rst_done` rises at E40.
  - `rst_n_out` is the bitwise inverse throughout.
- `sw_rst_req` pulse in DONE at edge k:
  - `rst_out`=1111 and `rst_done`=0 after edge k.
  - `rst_out[0]` falls at edge k+16.
  - `rst_done` rises at edge k+40.
- Async request: `rst_req_async` held high for 5 cycles starting at sample edge k.
  - Outputs assert after edge k+2.
  - The request deasserts through the synchronizer; release begins 16 edges after the last edge that saw `req`=1.
- Abort during RELEASE: `sw_rst_req` at E28, when `rst_out`=1100.
  - `rst_out`=1111 after E28.
  - Fresh sequence: `rst_out[0]` falls at E44, `rst_done` rises at E68.
- `rst` reasserted at E30 for 2 cycles:
  - All outputs return to 1 and `rst_done` to 0 on the next edge.
  - The sequence restarts relative to the new E1.
- Parameter corner: NUMBER_OF_RSTS=1, MIN_ASSERT_CYCLES=1, RELEASE_STEP=1.
  - `rst_out[0]` falls and `rst_done` rises together at E1.
  - A `sw_rst_req` pulse gives exactly one asserted cycle.
